// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program as a byte stream, packs the bytes into
// little-endian 32-bit words, writes them sequentially into instruction memory
// and keeps the core in reset until the whole image has been written.
module imem_boot_loader #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    input  logic                  in_restart,
    output logic                  out_imem_write_enable,
    output logic [ADDR_WIDTH-1:0] out_imem_addr,
    output logic [31:0]           out_imem_data,
    output logic                  out_core_reset,
    output logic                  out_done,
    output logic                  out_error,
    output logic [ADDR_WIDTH:0]   out_word_count
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           part_q, part_d;       // lanes 0..2 of the word in flight
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  core_rst_q, core_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer_c;
    logic                  last_byte_c;
    logic [WORD_W-1:0]     word_c;
    logic [CNT_W-1:0]      word_cnt_inc_c;

    // Handshake and word assembly helpers; word_c is only meaningful on lane 3.
    assign in_ready       = (state_q == S_HEADER) || (state_q == S_LOAD);
    assign xfer_c         = in_valid && in_ready;
    assign last_byte_c    = xfer_c && (byte_cnt_q == 2'd3);
    assign word_c         = {in_byte, part_q};
    assign word_cnt_inc_c = word_cnt_q + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; restart overrides everything.
    always_comb begin
        state_d = state_q;
        if (in_restart) begin
            state_d = S_HEADER;
        end else begin
            case (state_q)
                S_HEADER: begin
                    if (last_byte_c) begin
                        if (word_c == '0) begin
                            state_d = S_DONE;
                        end else if (word_c > WORD_W'(DEPTH)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (last_byte_c) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_d = (word_cnt_inc_c == len_q) ? S_DONE : S_LOAD;
                end
                S_DONE:  state_d = S_DONE;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_HEADER;
            endcase
        end
    end

    // Datapath and registered outputs; status flags follow the next state.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        part_d     = part_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);

        if (in_restart) begin
            byte_cnt_d = '0;
            part_d     = '0;
            word_cnt_d = '0;
        end else begin
            if (xfer_c) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    part_d[7:0]   = in_byte;
                    2'd1:    part_d[15:8]  = in_byte;
                    2'd2:    part_d[23:16] = in_byte;
                    default: part_d        = part_q;
                endcase
            end
            if ((state_q == S_HEADER) && last_byte_c) begin
                len_d = CNT_W'(word_c);
            end
            // Strobe is launched on the edge that takes byte 3, so it is high in S_WRITE.
            if ((state_q == S_LOAD) && last_byte_c) begin
                we_d   = 1'b1;
                addr_d = word_cnt_q[ADDR_WIDTH-1:0];
                data_d = word_c;
            end
            if (state_q == S_WRITE) begin
                word_cnt_d = word_cnt_inc_c;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= '0;
            part_q     <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            part_q     <= part_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign out_imem_write_enable = we_q;
    assign out_imem_addr         = addr_q;
    assign out_imem_data         = data_q;
    assign out_core_reset        = core_rst_q;
    assign out_done              = done_q;
    assign out_error             = err_q;
    assign out_word_count        = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: byte-stream loads with hand-computed
// expected strobes, status flags and timing.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        in_restart;
    logic        out_imem_write_enable;
    logic [9:0]  out_imem_addr;
    logic [31:0] out_imem_data;
    logic        out_core_reset;
    logic        out_done;
    logic        out_error;
    logic [10:0] out_word_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0]  st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];
    logic        done_seen;
    int          done_cyc;

    logic [31:0] prog [11] = '{32'h00000013, 32'h00000013, 32'h00000013,
                               32'h03200093, 32'h02300113, 32'h01400193,
                               32'h00f00213, 32'h002080b3, 32'h003080b3,
                               32'h004080b3, 32'h002081b3};

    imem_boot_loader #(.DEPTH(1024), .ADDR_WIDTH(10)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_byte               (in_byte),
        .in_ready              (in_ready),
        .in_restart            (in_restart),
        .out_imem_write_enable (out_imem_write_enable),
        .out_imem_addr         (out_imem_addr),
        .out_imem_data         (out_imem_data),
        .out_core_reset        (out_core_reset),
        .out_done              (out_done),
        .out_error             (out_error),
        .out_word_count        (out_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and the first cycle out_done is seen high.
    always @(negedge clk) begin
        if (out_imem_write_enable) begin
            st_addr.push_back(out_imem_addr);
            st_data.push_back(out_imem_data);
            st_cyc.push_back(cyc);
        end
        if (out_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        st_addr.delete();
        st_data.delete();
        st_cyc.delete();
        done_seen = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
            t = t >> 8;
        end
    endtask

    task automatic restart_pulse(input logic with_byte);
        in_restart = 1'b1;
        in_valid   = with_byte;
        in_byte    = 8'hFF;
        @(negedge clk);
        in_restart = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_we"},   32'(out_imem_write_enable), 32'd0);
        chk({pfx, "_addr"}, 32'(out_imem_addr),         32'd0);
        chk({pfx, "_data"}, out_imem_data,              32'd0);
        chk({pfx, "_crst"}, 32'(out_core_reset),        32'd1);
        chk({pfx, "_done"}, 32'(out_done),              32'd0);
        chk({pfx, "_err"},  32'(out_error),             32'd0);
        chk({pfx, "_wc"},   32'(out_word_count),        32'd0);
    endtask

    // The 11-word reference program, fed back to back.
    task automatic run_prog11(input string pfx);
        clear_log();
        send_word(32'd11, 0);
        for (int i = 0; i < 11; i++) send_word(prog[i], 0);
        repeat (3) @(negedge clk);
        chk({pfx, "_nstrobe"}, 32'(st_data.size()), 32'd11);
        if (st_data.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                chk($sformatf("%s_addr%0d", pfx, i), 32'(st_addr[i]), 32'(i));
                chk($sformatf("%s_data%0d", pfx, i), st_data[i], prog[i]);
            end
            chk({pfx, "_done_lat"}, 32'(done_cyc), 32'(st_cyc[10] + 1));
        end
        chk({pfx, "_wc"},   32'(out_word_count), 32'd11);
        chk({pfx, "_done"}, 32'(out_done),       32'd1);
        chk({pfx, "_crst"}, 32'(out_core_reset), 32'd0);
        chk({pfx, "_rdy"},  32'(in_ready),       32'd0);
    endtask

    initial begin
        int errs;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        in_restart = 1'b0;
        done_seen  = 1'b0;
        done_cyc   = 0;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reference program load.
        run_prog11("p1");

        // Restart then empty program.
        restart_pulse(1'b0);
        chk("rs_crst", 32'(out_core_reset), 32'd1);
        chk("rs_done", 32'(out_done),       32'd0);
        chk("rs_wc",   32'(out_word_count), 32'd0);
        clear_log();
        send_word(32'd0, 0);
        for (int i = 0; i < 2 && !out_done; i++) @(negedge clk);
        chk("n0_done", 32'(out_done),       32'd1);
        chk("n0_crst", 32'(out_core_reset), 32'd0);
        repeat (2) @(negedge clk);
        chk("n0_nstrobe", 32'(st_data.size()), 32'd0);

        // Oversized header.
        restart_pulse(1'b0);
        send_word(32'd1025, 0);
        chk("ovf_err",  32'(out_error),      32'd1);
        chk("ovf_rdy",  32'(in_ready),       32'd0);
        chk("ovf_crst", 32'(out_core_reset), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_hold", 32'(out_error),      32'd1);
        restart_pulse(1'b0);
        chk("ovf_clr_err", 32'(out_error), 32'd0);
        chk("ovf_clr_rdy", 32'(in_ready),  32'd1);

        // Two words with random idle gaps.
        clear_log();
        send_word(32'd2, 2);
        send_word(32'hDEADBEEF, 2);
        send_word(32'h12345678, 2);
        repeat (3) @(negedge clk);
        chk("gap_nstrobe", 32'(st_data.size()), 32'd2);
        if (st_data.size() == 2) begin
            chk("gap_addr0", 32'(st_addr[0]), 32'd0);
            chk("gap_data0", st_data[0],      32'hDEADBEEF);
            chk("gap_addr1", 32'(st_addr[1]), 32'd1);
            chk("gap_data1", st_data[1],      32'h12345678);
        end
        chk("gap_done", 32'(out_done),       32'd1);
        chk("gap_wc",   32'(out_word_count), 32'd2);

        // Restart in the middle of a word, with a byte offered in the same cycle.
        restart_pulse(1'b0);
        send_word(32'd3, 0);
        send_word(32'h11111111, 0);
        repeat (2) @(negedge clk);
        clear_log();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        restart_pulse(1'b1);
        repeat (3) @(negedge clk);
        chk("ab_nstrobe", 32'(st_data.size()), 32'd0);
        chk("ab_wc",      32'(out_word_count), 32'd0);
        chk("ab_crst",    32'(out_core_reset), 32'd1);
        send_word(32'd1, 0);
        send_word(32'hCAFEF00D, 0);
        repeat (3) @(negedge clk);
        chk("ab_nstrobe2", 32'(st_data.size()), 32'd1);
        if (st_data.size() == 1) begin
            chk("ab_addr", 32'(st_addr[0]), 32'd0);
            chk("ab_data", st_data[0],      32'hCAFEF00D);
        end
        chk("ab_done", 32'(out_done), 32'd1);

        // Asynchronous reset between edges, mid-word.
        restart_pulse(1'b0);
        send_word(32'd11, 0);
        send_word(prog[0], 0);
        send_word(32'h55667788, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #1 reset = 1'b0;
        #1 check_reset_vals("arst");
        #1 reset = 1'b1;
        @(negedge clk);
        run_prog11("p2");

        // Maximum length program: N == DEPTH.
        restart_pulse(1'b0);
        clear_log();
        send_word(32'd1024, 0);
        chk("max_noerr", 32'(out_error), 32'd0);
        for (int i = 0; i < 1024; i++) send_word(32'hA5000000 | 32'(i), 0);
        repeat (3) @(negedge clk);
        chk("max_nstrobe", 32'(st_data.size()), 32'd1024);
        if (st_data.size() == 1024) begin
            errs = 0;
            for (int i = 0; i < 1024; i++) begin
                if (st_addr[i] !== 10'(i) || st_data[i] !== (32'hA5000000 | 32'(i))) errs++;
            end
            chk("max_content", 32'(errs), 32'd0);
            chk("max_last_addr", 32'(st_addr[1023]), 32'd1023);
        end
        chk("max_wc",   32'(out_word_count), 32'd1024);
        chk("max_done", 32'(out_done),       32'd1);
        chk("max_crst", 32'(out_core_reset), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
